acc_pool_stream: RTL and testbench

- Parametrised successor of the accumulate/activate/pool path. Per lane: sums channel-tile partial sums, applies ReLU plus a requantise shift with saturation, then optionally pools 2x2/stride-2 (max or average).
- Emits one addressed 8-bit result stream per lane for the output buffer writer.
- Adds configurable lane count, pool mode, requantise shift, and multi-tile accumulation.

---
 rtl/acc_pool_pkg.sv | 25 ++
 rtl/acc_pool_lane.sv | 138 +++++++++++++
 rtl/acc_pool_stream.sv | 91 +++++++++
 tb/tb_acc_pool_stream.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pool_pkg.sv
// Shared types and helpers for the accumulate / activate / pool datapath.
package acc_pool_pkg;

   typedef enum logic [1:0] {
      BYPASS = 2'd0,
      MAX    = 2'd1,
      AVG    = 2'd2
   } pool_mode_e;

   localparam int ACC_W_DEF  = 24;
   localparam int DATA_W_DEF = 8;

   // ReLU, arithmetic right shift, then clamp to the unsigned data_w range.
   function automatic logic [31:0] sat_relu_shift(input logic signed [31:0] acc,
                                                  input logic [4:0]         shift,
                                                  input int unsigned        data_w);
      logic signed [31:0] shifted;
      logic [31:0]        limit;
      limit = (32'd1 << data_w) - 32'd1;
      if (acc < 0) return 32'd0;
      shifted = acc >>> shift;
      return (unsigned'(shifted) > limit) ? limit : unsigned'(shifted);
   endfunction

endpackage

// File: rtl/acc_pool_lane.sv
// One psum lane: tile accumulator, ReLU/requantise stage, 2x2 pool stage with
// half-width row buffer, and the row/col counters that address the results.
module acc_pool_lane
   import acc_pool_pkg::*;
#(
   parameter int PSUM_W    = 16,
   parameter int ACC_W     = ACC_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_OFMAP = 32,
   parameter int ADDR_W    = 10
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     busy,
   input  logic [5:0]               size,
   input  logic [5:0]               tiles,
   input  logic [4:0]               shift,
   input  logic [1:0]               mode,
   input  logic signed [PSUM_W-1:0] psum,
   input  logic                     pvalid,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [ADDR_W-1:0]        out_addr,
   output logic                     lane_last,
   output logic                     lane_done
);

   localparam int BUF_N = MAX_OFMAP / 2;
   localparam int IDX_W = (BUF_N > 1) ? $clog2(BUF_N) : 1;
   localparam int SUM_W = DATA_W + 2;

   logic [5:0]               tiles_eff, tile_cnt;
   logic                     tile_last, beat;
   logic signed [ACC_W-1:0]  ext, acc_sum, acc_p0;
   logic [DATA_W-1:0]        act_p1, hold;
   logic                     vld_p1;
   logic [5:0]               col, row, half;
   logic [SUM_W-1:0]         rowbuf [BUF_N];
   logic [IDX_W-1:0]         bidx;
   logic [SUM_W-1:0]         a_ext, h_ext, pair, above, quad_sum;
   logic [DATA_W-1:0]        pool_val;
   logic                     is_max, is_pool, last_col, last_row, final_win;
   logic [ADDR_W-1:0]        byp_addr, pool_addr;

   assign tiles_eff = (tiles == 6'd0) ? 6'd1 : tiles;
   assign tile_last = (tile_cnt == tiles_eff - 6'd1);
   assign beat      = busy && pvalid;
   assign ext       = ACC_W'(psum);
   assign acc_sum   = (tile_cnt == 6'd0) ? ext : acc_p0 + ext;

   // p0: tile accumulation; p1: activation captured on a pixel's last beat
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tile_cnt <= '0;
         acc_p0   <= '0;
         act_p1   <= '0;
         vld_p1   <= 1'b0;
      end else if (start) begin
         tile_cnt <= '0;
         vld_p1   <= 1'b0;
      end else begin
         vld_p1 <= beat && tile_last;
         if (beat) begin
            acc_p0   <= acc_sum;
            tile_cnt <= tile_last ? 6'd0 : tile_cnt + 6'd1;
            if (tile_last)
               act_p1 <= DATA_W'(sat_relu_shift(32'(acc_sum), shift, DATA_W));
         end
      end
   end

   assign is_max    = (mode == MAX);
   assign is_pool   = is_max || (mode == AVG);
   assign bidx      = IDX_W'(col >> 1);
   assign a_ext     = SUM_W'(act_p1);
   assign h_ext     = SUM_W'(hold);
   assign pair      = is_max ? ((a_ext > h_ext) ? a_ext : h_ext) : a_ext + h_ext;
   assign above     = rowbuf[bidx];
   assign quad_sum  = pair + above + SUM_W'(2);
   assign pool_val  = is_max ? DATA_W'((pair > above) ? pair : above) : DATA_W'(quad_sum >> 2);
   assign half      = size >> 1;
   assign last_col  = (col == size - 6'd1);
   assign last_row  = (row == size - 6'd1);
   assign final_win = ((row >> 1) == half - 6'd1) && ((col >> 1) == half - 6'd1);
   assign byp_addr  = ADDR_W'(row) * ADDR_W'(size) + ADDR_W'(col);
   assign pool_addr = ADDR_W'(row >> 1) * ADDR_W'(half) + ADDR_W'(col >> 1);

   // p2: pooling and output; odd trailing row/col fall out naturally (never emit)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col       <= '0;
         row       <= '0;
         hold      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_addr  <= '0;
         lane_last <= 1'b0;
         lane_done <= 1'b0;
         for (int i = 0; i < BUF_N; i++) rowbuf[i] <= '0;
      end else if (start) begin
         col       <= '0;
         row       <= '0;
         out_valid <= 1'b0;
         lane_last <= 1'b0;
         lane_done <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         lane_last <= 1'b0;
         if (vld_p1) begin
            if (last_col) begin
               col <= '0;
               row <= last_row ? 6'd0 : row + 6'd1;
            end else begin
               col <= col + 6'd1;
            end
            if (last_col && last_row) lane_done <= 1'b1;

            if (!is_pool) begin
               out_valid <= 1'b1;
               out_data  <= act_p1;
               out_addr  <= byp_addr;
               lane_last <= last_col && last_row;
            end else if (!col[0]) begin
               hold <= act_p1;
            end else if (!row[0]) begin
               rowbuf[bidx] <= pair;
            end else begin
               out_valid <= 1'b1;
               out_data  <= pool_val;
               out_addr  <= pool_addr;
               lane_last <= final_win;
            end
         end
      end
   end

endmodule

// File: rtl/acc_pool_stream.sv
// LANES independent accumulate/activate/pool lanes sharing one latched layer
// configuration, with layer start, busy and all-lanes-done control.
module acc_pool_stream
   import acc_pool_pkg::*;
#(
   parameter int LANES     = 16,
   parameter int PSUM_W    = 16,
   parameter int ACC_W     = ACC_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_OFMAP = 32,
   parameter int ADDR_W    = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cfg_start_i,
   input  logic [5:0]                cfg_ofmap_size_i,
   input  logic [5:0]                cfg_ch_tiles_i,
   input  logic [4:0]                cfg_shift_i,
   input  logic [1:0]                cfg_mode_i,
   input  logic [LANES*PSUM_W-1:0]   psum_i,
   input  logic [LANES-1:0]          pvalid_i,
   output logic                      busy_o,
   output logic [LANES-1:0]          out_valid_o,
   output logic [LANES*DATA_W-1:0]   out_data_o,
   output logic [LANES*ADDR_W-1:0]   out_addr_o,
   output logic [LANES-1:0]          lane_last_o,
   output logic                      done_o
);

   logic             busy, done, start_ok;
   logic [5:0]       cfg_size, cfg_tiles;
   logic [4:0]       cfg_shift;
   logic [1:0]       cfg_mode;
   logic [LANES-1:0] lane_done;

   assign start_ok = cfg_start_i && !busy;

   // Busy drops together with the done pulse, one cycle after the slowest lane finishes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         cfg_size  <= '0;
         cfg_tiles <= '0;
         cfg_shift <= '0;
         cfg_mode  <= '0;
      end else begin
         done <= 1'b0;
         if (start_ok) begin
            busy      <= 1'b1;
            cfg_size  <= cfg_ofmap_size_i;
            cfg_tiles <= cfg_ch_tiles_i;
            cfg_shift <= cfg_shift_i;
            cfg_mode  <= cfg_mode_i;
         end else if (busy && (&lane_done)) begin
            busy <= 1'b0;
            done <= 1'b1;
         end
      end
   end

   assign busy_o = busy;
   assign done_o = done;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      acc_pool_lane #(
         .PSUM_W    (PSUM_W),
         .ACC_W     (ACC_W),
         .DATA_W    (DATA_W),
         .MAX_OFMAP (MAX_OFMAP),
         .ADDR_W    (ADDR_W)
      ) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .start     (start_ok),
         .busy      (busy),
         .size      (cfg_size),
         .tiles     (cfg_tiles),
         .shift     (cfg_shift),
         .mode      (cfg_mode),
         .psum      (psum_i[g*PSUM_W +: PSUM_W]),
         .pvalid    (pvalid_i[g]),
         .out_valid (out_valid_o[g]),
         .out_data  (out_data_o[g*DATA_W +: DATA_W]),
         .out_addr  (out_addr_o[g*ADDR_W +: ADDR_W]),
         .lane_last (lane_last_o[g]),
         .lane_done (lane_done[g])
      );
   end

endmodule

// File: tb/tb_acc_pool_stream.sv
// Scoreboard bench for acc_pool_stream: a behavioural model of accumulate, ReLU/shift
// and 2x2 pooling queues expected results with their due cycle as each pixel is driven.
module tb_acc_pool_stream;

   localparam int LANES  = 16;
   localparam int PSUM_W = 16;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 10;

   logic                    clk, rst_n, cfg_start_i;
   logic [5:0]              cfg_ofmap_size_i, cfg_ch_tiles_i;
   logic [4:0]              cfg_shift_i;
   logic [1:0]              cfg_mode_i;
   logic [LANES*PSUM_W-1:0] psum_i;
   logic [LANES-1:0]        pvalid_i;
   logic                    busy_o, done_o;
   logic [LANES-1:0]        out_valid_o, lane_last_o;
   logic [LANES*DATA_W-1:0] out_data_o;
   logic [LANES*ADDR_W-1:0] out_addr_o;

   acc_pool_stream dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cfg_start_i      (cfg_start_i),
      .cfg_ofmap_size_i (cfg_ofmap_size_i),
      .cfg_ch_tiles_i   (cfg_ch_tiles_i),
      .cfg_shift_i      (cfg_shift_i),
      .cfg_mode_i       (cfg_mode_i),
      .psum_i           (psum_i),
      .pvalid_i         (pvalid_i),
      .busy_o           (busy_o),
      .out_valid_o      (out_valid_o),
      .out_data_o       (out_data_o),
      .out_addr_o       (out_addr_o),
      .lane_last_o      (lane_last_o),
      .done_o           (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int lane;
      int addr;
      int data;
      bit last;
      int due;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passes = 0;
   bit   mon_en = 1'b1;

   function automatic int act_model(input int acc, input int sh);
      int a;
      if (acc < 0) return 0;
      a = acc >>> sh;
      return (a > 255) ? 255 : a;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic monitor();
      int k, d, a;
      bit lst;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            for (int l = 0; l < LANES; l++) begin
               if (out_valid_o[l] === 1'b1) begin
                  k = -1;
                  for (int i = 0; i < exp_q.size(); i++) begin
                     if (exp_q[i].lane == l) begin
                        k = i;
                        break;
                     end
                  end
                  d   = int'(out_data_o[l*DATA_W +: DATA_W]);
                  a   = int'(out_addr_o[l*ADDR_W +: ADDR_W]);
                  lst = lane_last_o[l];
                  checks++;
                  if (k < 0) begin
                     $display("FAIL unexpected_out lane=%0d got data=%0d addr=%0d cyc=%0d, none expected",
                              l, d, a, cyc);
                  end else begin
                     if (d !== exp_q[k].data || a !== exp_q[k].addr || lst !== exp_q[k].last ||
                         cyc != exp_q[k].due)
                        $display("FAIL result lane=%0d got data=%0d addr=%0d last=%0d cyc=%0d, want data=%0d addr=%0d last=%0d cyc=%0d",
                                 l, d, a, lst, cyc, exp_q[k].data, exp_q[k].addr, exp_q[k].last, exp_q[k].due);
                     else
                        passes++;
                     exp_q.delete(k);
                  end
               end
            end
         end
      end
   endtask

   task automatic run_layer(input int s, input int t, input int sh, input int md,
                            input bit gap, input bit glitch, input int step, input int base[$]);
      int te, n, last_drv, done_cyc, v, p, k, r, c, val, addr, hs;
      int q0, q1, q2, q3;
      bit any;
      int idx[LANES];
      int acc[LANES];
      int px[LANES][1024];
      exp_t e;
      te = (t == 0) ? 1 : t;
      n  = s * s * te;
      hs = s / 2;
      for (int l = 0; l < LANES; l++) begin
         idx[l] = 0;
         acc[l] = 0;
      end
      last_drv = 0;
      @(negedge clk);
      cfg_ofmap_size_i = 6'(s);
      cfg_ch_tiles_i   = 6'(t);
      cfg_shift_i      = 5'(sh);
      cfg_mode_i       = 2'(md);
      cfg_start_i      = 1'b1;
      for (int cy = 0; cy < 4000; cy++) begin
         @(negedge clk);
         cfg_start_i = 1'b0;
         if (cy == 0) begin
            checks++;
            if (busy_o !== 1'b1) $display("FAIL busy_rise got %b want 1", busy_o);
            else passes++;
         end
         if (glitch && cy == 1) begin
            cfg_start_i      = 1'b1;
            cfg_ofmap_size_i = 6'(s + 2);
            cfg_ch_tiles_i   = 6'(te + 1);
            cfg_mode_i       = 2'(md ^ 1);
         end
         pvalid_i = '0;
         for (int l = 0; l < LANES; l++) begin
            if (idx[l] < n && (!gap || $urandom_range(0, l) == 0)) begin
               v = base[idx[l]] + l * step;
               p = idx[l] / te;
               k = idx[l] % te;
               psum_i[l*PSUM_W +: PSUM_W] = PSUM_W'(v);
               pvalid_i[l] = 1'b1;
               acc[l] = (k == 0) ? v : acc[l] + v;
               if (k == te - 1) begin
                  r = p / s;
                  c = p % s;
                  px[l][p] = act_model(acc[l], sh);
                  last_drv = cyc;
                  if (md == 1 || md == 2) begin
                     if (r % 2 == 1 && c % 2 == 1 && r < hs * 2 && c < hs * 2) begin
                        q0 = px[l][(r-1)*s + c-1];
                        q1 = px[l][(r-1)*s + c];
                        q2 = px[l][r*s + c-1];
                        q3 = px[l][r*s + c];
                        if (md == 1) val = max2(max2(q0, q1), max2(q2, q3));
                        else         val = (q0 + q1 + q2 + q3 + 2) >> 2;
                        addr   = (r / 2) * hs + c / 2;
                        e.lane = l; e.addr = addr; e.data = val;
                        e.last = (addr == hs * hs - 1); e.due = cyc + 2;
                        exp_q.push_back(e);
                     end
                  end else begin
                     e.lane = l; e.addr = p; e.data = px[l][p];
                     e.last = (p == s * s - 1); e.due = cyc + 2;
                     exp_q.push_back(e);
                  end
               end
               idx[l]++;
            end
         end
         any = 1'b0;
         for (int l = 0; l < LANES; l++) if (idx[l] < n) any = 1'b1;
         if (!any) break;
      end
      @(negedge clk);
      pvalid_i = '0;
      done_cyc = -1;
      for (int cy = 0; cy < 20; cy++) begin
         if (done_o === 1'b1) begin
            done_cyc = cyc;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (done_cyc != last_drv + 3) $display("FAIL done_timing got cyc %0d want cyc %0d", done_cyc, last_drv + 3);
      else passes++;
      checks++;
      if (busy_o !== 1'b0) $display("FAIL busy_fall got %b want 0", busy_o);
      else passes++;
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0) $display("FAIL done_pulse got %b want 0", done_o);
      else passes++;
      checks++;
      if (exp_q.size() != 0) $display("FAIL pending_results got %0d outstanding want 0", exp_q.size());
      else passes++;
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0) $display("FAIL reset_ctrl got busy=%b done=%b want 0 0", busy_o, done_o);
      else passes++;
      checks++;
      if (out_valid_o !== '0 || lane_last_o !== '0) $display("FAIL reset_valid got %h/%h want 0/0", out_valid_o, lane_last_o);
      else passes++;
      checks++;
      if (out_data_o !== '0 || out_addr_o !== '0) $display("FAIL reset_data got %h/%h want 0/0", out_data_o, out_addr_o);
      else passes++;
      rst_n = 1'b1;
   endtask

   task automatic test_bypass();
      int b[$];
      for (int i = 0; i < 16; i++) b.push_back(i);
      run_layer(4, 1, 0, 0, 1'b0, 1'b0, 16, b);
   endtask

   task automatic test_accum();
      int b1[$] = '{100, -300, 50, 300, 300, 100, 40, 40, 40, -5, 10, 2};
      int b2[$] = '{40, 40, 40, 100, -300, 50, 0, 0, 1, 1000, 1000, -900};
      int b3[$] = '{5, -7, 300, 1000};
      run_layer(2, 3, 1, 0, 1'b0, 1'b0, 3, b1);
      run_layer(2, 3, 2, 0, 1'b0, 1'b0, 3, b2);
      run_layer(2, 0, 0, 0, 1'b0, 1'b0, 1, b3);
   endtask

   task automatic test_max_pool();
      int b[$];
      for (int i = 0; i < 16; i++) b.push_back((i / 4) * 4 + (i % 4));
      run_layer(4, 1, 0, 1, 1'b0, 1'b0, 2, b);
   endtask

   task automatic test_avg_pool();
      int b1[$] = '{1, 2, 2, 2};
      int b2[$] = '{1, 1, 1, 2};
      int b3[$];
      run_layer(2, 1, 0, 2, 1'b0, 1'b0, 1, b1);
      run_layer(2, 1, 0, 2, 1'b0, 1'b0, 1, b2);
      for (int i = 0; i < 72; i++) b3.push_back(int'($urandom_range(0, 400)) - 60);
      run_layer(6, 2, 1, 2, 1'b0, 1'b0, 5, b3);
   endtask

   task automatic test_odd_size();
      int b[$];
      for (int i = 0; i < 25; i++) b.push_back(int'($urandom_range(0, 600)));
      run_layer(5, 1, 1, 1, 1'b0, 1'b0, 7, b);
   endtask

   task automatic test_control();
      int  b1[$] = '{9, 300, -4, 77};
      int  b2[$];
      bit  seen;
      run_layer(2, 1, 0, 0, 1'b0, 1'b1, 2, b1);

      mon_en = 1'b0;
      @(negedge clk);
      cfg_ofmap_size_i = 6'd4;
      cfg_ch_tiles_i   = 6'd2;
      cfg_shift_i      = 5'd0;
      cfg_mode_i       = 2'd0;
      cfg_start_i      = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         cfg_start_i = 1'b0;
         pvalid_i    = '1;
         psum_i      = {LANES{16'sd50}};
      end
      @(negedge clk);
      rst_n    = 1'b0;
      pvalid_i = '0;
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0) $display("FAIL abort_ctrl got busy=%b done=%b want 0 0", busy_o, done_o);
      else passes++;
      checks++;
      if (out_valid_o !== '0 || lane_last_o !== '0 || out_data_o !== '0 || out_addr_o !== '0)
         $display("FAIL abort_outputs got valid=%h last=%h want all 0", out_valid_o, lane_last_o);
      else passes++;
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done_o !== 1'b0 || out_valid_o !== '0 || busy_o !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) $display("FAIL abort_silent got activity after reset want none");
      else passes++;
      mon_en = 1'b1;

      for (int i = 0; i < 9; i++) b2.push_back(int'($urandom_range(0, 300)));
      run_layer(3, 1, 0, 2, 1'b0, 1'b0, 4, b2);
   endtask

   task automatic test_staggered();
      int b[$];
      for (int i = 0; i < 32; i++) b.push_back(int'($urandom_range(0, 500)) - 100);
      run_layer(4, 2, 1, 2, 1'b1, 1'b0, 3, b);
      b.delete();
      for (int i = 0; i < 16; i++) b.push_back(int'($urandom_range(0, 300)));
      run_layer(4, 1, 0, 0, 1'b1, 1'b0, 1, b);
   endtask

   initial begin
      rst_n            = 1'b0;
      cfg_start_i      = 1'b0;
      cfg_ofmap_size_i = '0;
      cfg_ch_tiles_i   = '0;
      cfg_shift_i      = '0;
      cfg_mode_i       = '0;
      psum_i           = '0;
      pvalid_i         = '0;
      fork
         monitor();
      join_none
      test_reset();
      test_bypass();
      test_accum();
      test_max_pool();
      test_avg_pool();
      test_odd_size();
      test_control();
      test_staggered();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
